// File: rtl/sdram_bus_bridge.sv
// 32-bit bus to 16-bit SDRAM controller host-port bridge: splits word accesses into half-words and reassembles reads.
// Optional posted writes (ack right after acceptance) are enabled by defining SDRAM_BRIDGE_POSTED_WRITE_EN.
module sdram_bus_bridge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_access,
  input  logic [31:0] bus_addr,
  input  logic        bus_wr_en,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_bytesel,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic [31:0] c_addr,
  output logic [15:0] c_wdata,
  input  logic [15:0] c_rdata,
  output logic        c_wr_en,
  output logic [1:0]  c_bytesel,
  input  logic        c_compl,
  input  logic        c_config_done
);

`ifdef SDRAM_BRIDGE_POSTED_WRITE_EN
  localparam logic POSTED_WR = 1'b1;
`else
  localparam logic POSTED_WR = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic [31:0] c_addr_q, c_addr_d;
  logic [15:0] c_wdata_q, c_wdata_d;
  logic        c_wr_q, c_wr_d;
  logic [1:0]  c_sel_q, c_sel_d;

  logic        accept;
  logic [29:0] src_addr;
  logic        src_wr;
  logic [31:0] src_wdata;
  logic [3:0]  src_sel;
  logic [15:0] lane_mask;
  logic [15:0] rd_masked;
  state_e      done_state;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus_addr[1:0];

  assign accept = (state_q == IDLE) && bus_access && c_config_done;

  // The request presented in the cycle after acceptance must come straight from the bus inputs.
  assign src_addr  = accept ? bus_addr[31:2] : addr_q;
  assign src_wr    = accept ? bus_wr_en      : wr_q;
  assign src_wdata = accept ? bus_wdata      : wdata_q;
  assign src_sel   = accept ? bus_bytesel    : sel_q;

  assign lane_mask = (state_q == HI) ? {{8{sel_q[3]}}, {8{sel_q[2]}}}
                                     : {{8{sel_q[1]}}, {8{sel_q[0]}}};
  assign rd_masked = c_rdata & lane_mask;

  // A posted write was already acknowledged, so its final completion returns straight to IDLE.
  assign done_state = (POSTED_WR && wr_q) ? IDLE : ACK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (|bus_bytesel[1:0])      state_d = LO;
          else if (|bus_bytesel[3:2]) state_d = HI;
          else                        state_d = ACK;
        end
      end
      LO:      if (c_compl) state_d = (|sel_q[3:2]) ? HI : done_state;
      HI:      if (c_compl) state_d = done_state;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    c_addr_d  = c_addr_q;
    c_wdata_d = c_wdata_q;
    c_sel_d   = 2'b00;
    c_wr_d    = 1'b0;
    ack_d     = (state_d == ACK) || (accept && POSTED_WR && bus_wr_en);

    if (accept) begin
      addr_d  = bus_addr[31:2];
      wr_d    = bus_wr_en;
      wdata_d = bus_wdata;
      sel_d   = bus_bytesel;
      rdata_d = 32'h0;
    end

    if (c_compl && !wr_q) begin
      if (state_q == LO) rdata_d[15:0]  = rd_masked;
      if (state_q == HI) rdata_d[31:16] = rd_masked;
    end

    // Request lines follow the state being entered; anything else idles the controller port.
    case (state_d)
      LO: begin
        c_addr_d  = {src_addr, 2'b00};
        c_wdata_d = src_wdata[15:0];
        c_sel_d   = src_sel[1:0];
        c_wr_d    = src_wr;
      end
      HI: begin
        c_addr_d  = {src_addr, 2'b10};
        c_wdata_d = src_wdata[31:16];
        c_sel_d   = src_sel[3:2];
        c_wr_d    = src_wr;
      end
      default: begin
        c_sel_d = 2'b00;
        c_wr_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
      c_wr_q    <= 1'b0;
      c_sel_q   <= 2'b00;
    end else begin
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
      c_wr_q    <= c_wr_d;
      c_sel_q   <= c_sel_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ack   = ack_q;
  assign c_addr    = c_addr_q;
  assign c_wdata   = c_wdata_q;
  assign c_wr_en   = c_wr_q;
  assign c_bytesel = c_sel_q;

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// Bench for sdram_bus_bridge: table vectors, corner-case sequences and random traffic against a byte-level memory model.
module tb_sdram_bus_bridge;

`ifdef SDRAM_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_access = 1'b0;
  logic [31:0] bus_addr = '0;
  logic        bus_wr_en = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [3:0]  bus_bytesel = '0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] c_addr;
  logic [15:0] c_wdata;
  logic [15:0] c_rdata = '0;
  logic        c_wr_en;
  logic [1:0]  c_bytesel;
  logic        c_compl;
  logic        c_config_done = 1'b0;
  logic        model_compl = 1'b0;
  logic        force_compl = 1'b0;

  assign c_compl = model_compl | force_compl;

  always #5 clk = ~clk;

  sdram_bus_bridge dut (
    .clk(clk), .rst_n(rst_n), .bus_access(bus_access), .bus_addr(bus_addr),
    .bus_wr_en(bus_wr_en), .bus_wdata(bus_wdata), .bus_bytesel(bus_bytesel),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_wr_en(c_wr_en), .c_bytesel(c_bytesel), .c_compl(c_compl),
    .c_config_done(c_config_done)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  sel;
    logic        we;
  } acc_t;

  acc_t        log_q[$];
  acc_t        exp_q[$];
  logic [15:0] cmem [logic [30:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  int          max_delay = 0;
  bit          stall_hi = 1'b0;
  int          proto_err = 0;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Controller model: one half-word access at a time, completes after a random delay.
  initial begin
    bit   active;
    acc_t cur;
    int   cnt;
    active = 1'b0;
    cnt = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      model_compl = 1'b0;
      c_rdata = 16'($urandom);
      if (!rst_n) begin
        active = 1'b0;
        continue;
      end
      if (c_bytesel == 2'b00 && c_wr_en) proto_err++;
      if (!active && c_bytesel != 2'b00) begin
        active = 1'b1;
        cur.addr = c_addr; cur.wdata = c_wdata; cur.sel = c_bytesel; cur.we = c_wr_en;
        cnt = $urandom_range(max_delay, 0);
      end else if (active && (c_addr !== cur.addr || c_wdata !== cur.wdata ||
                              c_bytesel !== cur.sel || c_wr_en !== cur.we)) begin
        proto_err++;
      end
      if (active && !(stall_hi && cur.addr[1])) begin
        if (cnt == 0) begin
          logic [15:0] w;
          w = cmem.exists(cur.addr[31:1]) ? cmem[cur.addr[31:1]] : 16'h0;
          model_compl = 1'b1;
          c_rdata = w;
          if (cur.we) begin
            if (cur.sel[0]) w[7:0]  = cur.wdata[7:0];
            if (cur.sel[1]) w[15:8] = cur.wdata[15:8];
            cmem[cur.addr[31:1]] = w;
          end
          log_q.push_back(cur);
          active = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [3:0] bs);
    logic [31:0] r;
    logic [31:0] base;
    r = '0;
    base = {a[31:2], 2'b00};
    for (int n = 0; n < 4; n++)
      if (bs[n] && ref_mem.exists(base + n)) r[8*n +: 8] = ref_mem[base + n];
    return r;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] bs);
    logic [31:0] base;
    base = {a[31:2], 2'b00};
    for (int n = 0; n < 4; n++)
      if (bs[n]) ref_mem[base + n] = wd[8*n +: 8];
  endtask

  task automatic build_exp(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] bs);
    acc_t e;
    exp_q.delete();
    if (bs[1:0] != 2'b00) begin
      e.addr = {a[31:2], 2'b00}; e.wdata = wd[15:0]; e.sel = bs[1:0]; e.we = we;
      exp_q.push_back(e);
    end
    if (bs[3:2] != 2'b00) begin
      e.addr = {a[31:2], 2'b10}; e.wdata = wd[31:16]; e.sel = bs[3:2]; e.we = we;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] bs, input bit wait_log, input bit scramble,
                         output logic [31:0] rd, output int lat);
    bit got;
    int n;
    int nexp;
    nexp = int'(bs[1:0] != 2'b00) + int'(bs[3:2] != 2'b00);
    log_q.delete();
    @(negedge clk);
    bus_addr = a; bus_wr_en = we; bus_wdata = wd; bus_bytesel = bs; bus_access = 1'b1;
    got = 1'b0; lat = 0; rd = '0;
    while (!got && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (scramble && lat == 1) begin
        bus_addr = $urandom; bus_wdata = $urandom; bus_bytesel = 4'($urandom);
      end
      if (bus_ack) begin
        got = 1'b1;
        rd = bus_rdata;
        if (!(POSTED && we)) chk("ctrl_idle_at_ack", {61'h0, c_wr_en, c_bytesel}, 64'h0);
      end
    end
    bus_access = 1'b0;
    chk("ack_seen", {63'h0, got}, 64'h1);
    @(posedge clk); #1;
    chk("ack_single", {63'h0, bus_ack}, 64'h0);
    if (wait_log) begin
      n = 0;
      while (log_q.size() < nexp && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (we) ref_write(a, wd, bs);
    $display("txn %s addr=%h bs=%b wdata=%h rdata=%h lat=%0d acc=%0d",
             we ? "WR" : "RD", a, bs, wd, rd, lat, log_q.size());
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  bs;
    logic [31:0] exp_rdata;
    int          exp_nacc;
    logic [31:0] exp_first_addr;
    logic [15:0] exp_first_wdata;
  } vec_t;

  initial begin
    vec_t        tbl[10];
    logic [31:0] rd;
    int          lat;
    int          hold_err;
    bit          found;

    tbl[0] = '{32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'b1111, 32'h0,         2, 32'h1004, 16'hBEEF};
    tbl[1] = '{32'h0000_1004, 1'b0, 32'h0,         4'b1111, 32'hDEAD_BEEF, 2, 32'h1004, 16'h0};
    tbl[2] = '{32'h0000_0020, 1'b1, 32'h1122_3344, 4'b1100, 32'h0,         1, 32'h0022, 16'h1122};
    tbl[3] = '{32'h0000_0020, 1'b0, 32'h0,         4'b1111, 32'h1122_0000, 2, 32'h0020, 16'h0};
    tbl[4] = '{32'h0000_1004, 1'b0, 32'h0,         4'b0001, 32'h0000_00EF, 1, 32'h1004, 16'h0};
    tbl[5] = '{32'h0000_1004, 1'b0, 32'h0,         4'b0000, 32'h0,         0, 32'h0,    16'h0};
    tbl[6] = '{32'h0000_1004, 1'b1, 32'hAABB_CCDD, 4'b0110, 32'h0,         2, 32'h1004, 16'hCCDD};
    tbl[7] = '{32'h0000_1007, 1'b0, 32'h0,         4'b1111, 32'hDEBB_CCEF, 2, 32'h1004, 16'h0};
    tbl[8] = '{32'h0000_1004, 1'b0, 32'h0,         4'b1000, 32'hDE00_0000, 1, 32'h1006, 16'h0};
    tbl[9] = '{32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b0000, 32'h0,         0, 32'h0,    16'h0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_bus", {31'h0, bus_rdata, bus_ack}, 64'h0);
    chk("reset_ctrl", {13'h0, c_addr, c_wdata, c_wr_en, c_bytesel}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Requests stay pending until configuration is done; a stray completion in IDLE is ignored
    log_q.delete();
    @(negedge clk);
    bus_addr = 32'h0000_0040; bus_wr_en = 1'b0; bus_bytesel = 4'b0011; bus_access = 1'b1;
    hold_err = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (c_bytesel != 2'b00 || bus_ack) hold_err++;
      if (i == 3) force_compl = 1'b1;
      if (i == 4) force_compl = 1'b0;
    end
    chk("cfg_hold", 64'(hold_err), 64'h0);
    c_config_done = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (bus_ack) found = 1'b1;
    end
    bus_access = 1'b0;
    chk("cfg_ack", {63'h0, found}, 64'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("cfg_one_access", 64'(log_q.size()), 64'h1);

    // Table vectors with zero controller delay
    max_delay = 0;
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].addr, tbl[i].we, tbl[i].wdata, tbl[i].bs, 1'b1, 1'b1, rd, lat);
      chk($sformatf("tbl%0d_rdata", i), 64'(rd), 64'(tbl[i].exp_rdata));
      chk($sformatf("tbl%0d_nacc", i), 64'(log_q.size()), 64'(tbl[i].exp_nacc));
      chk($sformatf("tbl%0d_lat", i), 64'(lat),
          64'((POSTED && tbl[i].we) ? 1 : tbl[i].exp_nacc + 1));
      if (log_q.size() > 0) begin
        chk($sformatf("tbl%0d_caddr", i), 64'(log_q[0].addr), 64'(tbl[i].exp_first_addr));
        if (tbl[i].we) chk($sformatf("tbl%0d_cwdata", i), 64'(log_q[0].wdata), 64'(tbl[i].exp_first_wdata));
      end
    end

    // Reset asserted while the upper half-word is outstanding
    stall_hi = 1'b1;
    @(negedge clk);
    bus_addr = 32'h0000_1004; bus_wr_en = 1'b0; bus_bytesel = 4'b1111; bus_access = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (c_bytesel == 2'b11 && c_addr[1]) found = 1'b1;
    end
    chk("reached_hi", {63'h0, found}, 64'h1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_bus", {31'h0, bus_rdata, bus_ack}, 64'h0);
    chk("midrst_ctrl", {13'h0, c_addr, c_wdata, c_wr_en, c_bytesel}, 64'h0);
    bus_access = 1'b0;
    stall_hi = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(32'h0000_1004, 1'b0, 32'h0, 4'b1111, 1'b1, 1'b1, rd, lat);
    chk("after_rst_rdata", 64'(rd), 64'(32'hDEBB_CCEF));

`ifdef SDRAM_BRIDGE_POSTED_WRITE_EN
    // Posted write acknowledged early; the following read must still see its data
    max_delay = 3;
    run_txn(32'h0000_0200, 1'b1, 32'h1234_5678, 4'b1111, 1'b0, 1'b1, rd, lat);
    chk("posted_wr_lat", 64'(lat), 64'h1);
    run_txn(32'h0000_0200, 1'b0, 32'h0, 4'b1111, 1'b1, 1'b0, rd, lat);
    chk("posted_rd_after_wr", 64'(rd), 64'(32'h1234_5678));
    repeat (20) @(posedge clk);
`endif

    // Random traffic against the byte-level reference memory
    max_delay = 3;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic        we;
      logic [31:0] wd;
      logic [3:0]  bs;
      logic [31:0] exp_rd;
      a  = 32'h100 + (32'($urandom_range(15, 0)) << 2) + 32'($urandom_range(3, 0));
      we = 1'($urandom);
      wd = $urandom;
      bs = 4'($urandom);
      exp_rd = we ? 32'h0 : ref_read(a, bs);
      build_exp(a, we, wd, bs);
      run_txn(a, we, wd, bs, 1'b1, 1'b1, rd, lat);
      chk($sformatf("rnd%0d_rdata", t), 64'(rd), 64'(exp_rd));
      chk($sformatf("rnd%0d_nacc", t), 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
        chk($sformatf("rnd%0d_acc%0d", t, i), 64'(log_q[i]), 64'(exp_q[i]));
    end

    chk("ctrl_protocol", 64'(proto_err), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
